ds1302_responder: RTL and testbench

Synthesizable DS1302-compatible slave: the far end of the 3-wire CE/SCLK/IO bus that our DS1302 controller drives. It decodes command bytes, holds an 8-byte clock register file and a 31-byte RAM, executes single-byte reads and writes, and enforces the write-protect bit. It is used as an on-chip stand-in for the RTC in loopback and self-test builds. A side port lets local logic observe committed writes and peek at register contents. It does no timekeeping: the clock registers are plain storage.

---
 rtl/ds1302_responder.sv | 166 ++++++++++++++++
 tb/tb_ds1302_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ds1302_responder.sv
// DS1302-compatible 3-wire bus slave: 8 clock registers plus 31 bytes of RAM, single-byte
// transfers only, with write protect. A host side port observes commits and peeks at contents.
module ds1302_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ds1302_ce,
  input  logic       ds1302_sclk,
  inout  logic       ds1302_io,
  input  logic       host_sel,
  input  logic [4:0] host_addr,
  output logic [7:0] host_rdata,
  output logic       wr_strobe,
  output logic       wr_sel,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  // state | meaning
  // IDLE  | CE low, line released, waiting for CE
  // CMD   | shifting in the command byte on SCLK rise
  // WDATA | shifting in the write data byte on SCLK rise
  // RDATA | driving the read byte on SCLK fall, LSB first
  // DONE  | transfer finished or rejected; wait for CE low
  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DONE} state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] ce_sync, sclk_sync, io_sync;
  logic       ce_s, sclk_s, io_s, sclk_prev;
  logic       sclk_rise, sclk_fall;
  logic [3:0] bit_cnt;
  logic [6:0] shift;
  logic [7:0] shift_next;
  logic [7:0] rd_shift;
  logic       io_oe, io_out;
  logic       cmd_sel;
  logic [4:0] cmd_addr;
  logic [7:0] clk_regs [0:7];
  logic [7:0] ram      [0:30];

  assign ce_s      = ce_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign io_s      = io_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  // LSB first: each new bit enters at the top and the byte settles after eight shifts
  assign shift_next = {io_s, shift};

  assign ds1302_io = io_oe ? io_out : 1'bz;
  assign busy      = (state != IDLE);

  function automatic logic [7:0] read_byte(input logic sel, input logic [4:0] addr);
    if (sel) return (addr <= 5'd30) ? ram[addr] : 8'h00;
    return (addr <= 5'd7) ? clk_regs[addr[2:0]] : 8'h00;
  endfunction

  // Address 31 is burst mode, which falls outside both ranges and is rejected
  function automatic logic cmd_ok(input logic [7:0] c);
    if (!c[7]) return 1'b0;
    if (c[6]) return (c[5:1] <= 5'd30);
    return (c[5:1] <= 5'd7);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_sync   <= '0;
      sclk_sync <= '0;
      io_sync   <= '0;
      sclk_prev <= 1'b0;
    end else begin
      ce_sync   <= {ce_sync[SYNC_STAGES-2:0], ds1302_ce};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], ds1302_sclk};
      io_sync   <= {io_sync[SYNC_STAGES-2:0], ds1302_io};
      sclk_prev <= sclk_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      shift     <= 7'd0;
      rd_shift  <= 8'h00;
      io_oe     <= 1'b0;
      io_out    <= 1'b0;
      cmd_sel   <= 1'b0;
      cmd_addr  <= 5'd0;
      wr_strobe <= 1'b0;
      wr_sel    <= 1'b0;
      wr_addr   <= 5'd0;
      wr_data   <= 8'h00;
      for (int i = 0; i < 8; i++) clk_regs[i] <= 8'h00;
      for (int i = 0; i < 31; i++) ram[i] <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      if (!ce_s) begin
        state   <= IDLE;
        io_oe   <= 1'b0;
        bit_cnt <= 4'd0;
      end else begin
        case (state)
          IDLE: begin
            io_oe   <= 1'b0;
            bit_cnt <= 4'd0;
            state   <= CMD;
          end
          CMD: if (sclk_rise) begin
            shift   <= shift_next[7:1];
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt  <= 4'd0;
              cmd_sel  <= shift_next[6];
              cmd_addr <= shift_next[5:1];
              if (!cmd_ok(shift_next)) begin
                state <= DONE;
              end else if (shift_next[0]) begin
                rd_shift <= read_byte(shift_next[6], shift_next[5:1]);
                state    <= RDATA;
              end else begin
                state <= WDATA;
              end
            end
          end
          WDATA: if (sclk_rise) begin
            shift   <= shift_next[7:1];
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              // Register 7 stays writable so that write protect can always be cleared
              if (!clk_regs[7][7] || (!cmd_sel && cmd_addr == 5'd7)) begin
                if (cmd_sel) ram[cmd_addr] <= shift_next;
                else         clk_regs[cmd_addr[2:0]] <= shift_next;
                wr_strobe <= 1'b1;
                wr_sel    <= cmd_sel;
                wr_addr   <= cmd_addr;
                wr_data   <= shift_next;
              end
              state <= DONE;
            end
          end
          RDATA: if (sclk_fall) begin
            if (bit_cnt == 4'd8) begin
              io_oe <= 1'b0;
              state <= DONE;
            end else begin
              io_oe    <= 1'b1;
              io_out   <= rd_shift[0];
              rd_shift <= {1'b0, rd_shift[7:1]};
              bit_cnt  <= bit_cnt + 4'd1;
            end
          end
          DONE: io_oe <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) host_rdata <= 8'h00;
    else     host_rdata <= read_byte(host_sel, host_addr);
  end

endmodule

// File: tb/tb_ds1302_responder.sv
// Randomized bench for ds1302_responder: a bus master drives CE/SCLK/IO, a memory model predicts
// commits and read bytes, and monitors compare strobes and read results against queued expectations.
`timescale 1ns/1ps
module tb_ds1302_responder;
  localparam int H = 60;

  logic       clk = 1'b0;
  logic       rst, ce, sclk, host_sel;
  logic [4:0] host_addr, wr_addr;
  logic [7:0] host_rdata, wr_data;
  logic       wr_strobe, wr_sel, busy;
  logic       m_oe, m_out;
  wire        ds1302_io;

  assign ds1302_io = m_oe ? m_out : 1'bz;
  pullup (ds1302_io);

  always #5 clk = ~clk;

  ds1302_responder #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ds1302_ce(ce), .ds1302_sclk(sclk), .ds1302_io(ds1302_io),
    .host_sel(host_sel), .host_addr(host_addr), .host_rdata(host_rdata),
    .wr_strobe(wr_strobe), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  typedef struct {logic sel; logic [4:0] addr; logic [7:0] data;} wr_t;
  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] got_rd;
  event       rd_ev;
  logic [7:0] m_clk [8];
  logic [7:0] m_ram [31];
  int checks = 0, passes = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  function automatic bit cmd_valid(input logic [7:0] c);
    int a;
    a = c[5:1];
    if (c[7] == 1'b0) return 0;
    if (a == 31) return 0;
    if (c[6]) return a < 31;
    return a < 8;
  endfunction

  function automatic logic [7:0] model_peek(input logic sel, input logic [4:0] addr);
    if (sel) return (addr < 31) ? m_ram[addr] : 8'h00;
    return (addr < 8) ? m_clk[addr] : 8'h00;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_clk[i] = 8'h00;
    for (int i = 0; i < 31; i++) m_ram[i] = 8'h00;
  endtask

  task automatic send_bit(input logic b);
    m_oe = 1'b1; m_out = b;
    #H sclk = 1'b1;
    #H sclk = 1'b0;
  endtask

  task automatic start_tx();
    ce = 1'b1;
    #100;
  endtask

  task automatic end_tx();
    m_oe = 1'b0;
    #H ce = 1'b0;
    #100;
  endtask

  task automatic do_write(input logic [7:0] c, input logic [7:0] d);
    if (cmd_valid(c) && !c[0]) begin
      if (m_clk[7][7] == 1'b0 || (!c[6] && c[5:1] == 5'd7)) begin
        exp_wr.push_back('{sel: c[6], addr: c[5:1], data: d});
        if (c[6]) m_ram[c[5:1]] = d;
        else      m_clk[c[5:1]] = d;
      end
    end
    start_tx();
    for (int i = 0; i < 8; i++) send_bit(c[i]);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    end_tx();
  endtask

  task automatic do_abort(input logic [7:0] c, input logic [7:0] d, input int k);
    start_tx();
    for (int i = 0; i < 8; i++) send_bit(c[i]);
    for (int i = 0; i < k; i++) send_bit(d[i]);
    end_tx();
  endtask

  // Master releases IO after the last command rise; an undriven line reads 1 through the pull-up
  task automatic send_cmd_release(input logic [7:0] c);
    for (int i = 0; i < 7; i++) send_bit(c[i]);
    m_out = c[7];
    #H sclk = 1'b1;
    #10 m_oe = 1'b0;
    #(H-10) sclk = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] c);
    logic [7:0] rd;
    if (cmd_valid(c) && c[0]) exp_rd.push_back(model_peek(c[6], c[5:1]));
    else                      exp_rd.push_back(8'hFF);
    start_tx();
    send_cmd_release(c);
    for (int i = 0; i < 8; i++) begin
      #H rd[i] = ds1302_io;
      sclk = 1'b1;
      #H sclk = 1'b0;
    end
    #H check("io_release_after_read", ds1302_io, 1'b1);
    got_rd = rd;
    ->rd_ev;
    ce = 1'b0;
    #100;
  endtask

  task automatic peek_check(input logic sel, input logic [4:0] addr);
    @(negedge clk);
    host_sel = sel; host_addr = addr;
    @(negedge clk);
    check($sformatf("peek sel%0d addr%0d", sel, addr), host_rdata, model_peek(sel, addr));
  endtask

  always @(negedge clk) begin
    if (!rst && wr_strobe) begin
      if (exp_wr.size() == 0) begin
        checks++;
        $display("FAIL wr_unexpected: got strobe sel=%0d addr=%0d data=0x%0h expected none", wr_sel, wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        check("wr_sel", wr_sel, e.sel);
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", wr_data, e.data);
      end
    end
  end

  initial begin
    forever begin
      @(rd_ev);
      if (exp_rd.size() == 0) begin
        checks++;
        $display("FAIL rd_unexpected: got 0x%0h expected no read", got_rd);
      end else begin
        check("bus_read", got_rd, exp_rd.pop_front());
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       s, rw, b7;
    logic [4:0] a;
    logic [7:0] c, d;
    rst = 1'b1; ce = 1'b0; sclk = 1'b0; m_oe = 1'b0; m_out = 1'b0;
    host_sel = 1'b0; host_addr = 5'd0;
    model_clear();
    #33 rst = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_strobe", wr_strobe, 1'b0);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_wr_addr", wr_addr, 5'd0);
    check("rst_wr_sel", wr_sel, 1'b0);
    check("rst_host_rdata", host_rdata, 8'h00);
    check("rst_io", ds1302_io, 1'b1);

    do_write(8'h84, 8'h12);
    do_read(8'h85);
    peek_check(1'b0, 5'd2);
    check("peek_clk2_literal", host_rdata, 8'h12);

    do_write(8'hC0, 8'hA5);
    do_read(8'hC1);
    peek_check(1'b1, 5'd0);
    check("peek_ram0_literal", host_rdata, 8'hA5);

    do_write(8'h8E, 8'h80);
    do_write(8'h84, 8'h34);
    do_read(8'h85);
    peek_check(1'b0, 5'd2);
    do_write(8'h8E, 8'h00);
    peek_check(1'b0, 5'd7);

    start_tx();
    check("busy_during_tx", busy, 1'b1);
    for (int i = 0; i < 8; i++) send_bit(c_of(8'h84, i));
    for (int i = 0; i < 4; i++) send_bit(c_of(8'h55, i));
    m_oe = 1'b0; ce = 1'b0;
    #100;
    check("busy_after_abort", busy, 1'b0);
    check("io_after_abort", ds1302_io, 1'b1);
    peek_check(1'b0, 5'd2);

    do_read(8'h04);
    do_read(8'hBF);
    check("busy_after_invalid", busy, 1'b0);
    peek_check(1'b0, 5'd31);

    do_write(8'hC0, 8'hA5);
    start_tx();
    send_cmd_release(8'hC1);
    #H sclk = 1'b1;
    #H sclk = 1'b0;
    #H check("rd_bit1_driven", ds1302_io, 1'b0);
    rst = 1'b1;
    #1 check("io_release_on_rst", ds1302_io, 1'b1);
    ce = 1'b0; sclk = 1'b0;
    #50 rst = 1'b0;
    model_clear();
    for (int i = 0; i < 8; i++) peek_check(1'b0, 5'(i));
    for (int i = 0; i < 31; i++) peek_check(1'b1, 5'(i));
    check("busy_after_rst", busy, 1'b0);

    for (int n = 0; n < 40; n++) begin
      s  = 1'($urandom % 2);
      a  = 5'($urandom % 32);
      if (!s && ($urandom % 4) == 0) a = 5'd7;
      rw = 1'($urandom % 2);
      b7 = (($urandom % 8) != 0);
      c  = {b7, s, a, rw};
      d  = 8'($urandom);
      if (rw)                    do_read(c);
      else if ($urandom % 6 == 0) do_abort(c, d, $urandom_range(1, 7));
      else                       do_write(c, d);
      peek_check(1'($urandom % 2), 5'($urandom % 32));
    end

    #200;
    check("wr_queue_empty", exp_wr.size(), 0);
    check("rd_queue_empty", exp_rd.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  function automatic logic c_of(input logic [7:0] v, input int i);
    return v[i];
  endfunction

endmodule
